mnist_infer_seq: RTL and testbench

Inference sequencer for the 9-bit fixed-point ReLU MNIST engine. It accepts one classification request through a valid/ready handshake, then clears and starts the engine and waits for the engine's `done`. It then scans the ten class scores through the engine's `out_idx`/`out` read port, computes the argmax, and returns the predicted digit and its score through a second valid/ready handshake. It sits between the host/testbench control logic and the engine top; the weight/image memory path is not touched.

---
 rtl/mnist_infer_seq.sv | 166 ++++++++++++++++
 tb/tb_mnist_infer_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mnist_infer_seq.sv
// Request/response sequencer for the MNIST engine: clear, start, wait for done, argmax-scan the class scores.
// Optional watchdog in WAIT is built only when SEQ_TIMEOUT_EN is defined.
module mnist_infer_seq #(
  parameter int DATA_WIDTH     = 9,
  parameter int NUM_CLASSES    = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  output logic                         eng_reset,
  output logic                         eng_start,
  input  logic                         eng_done,
  output logic [3:0]                   eng_out_idx,
  input  logic signed [DATA_WIDTH-1:0] eng_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [3:0]                   res_digit,
  output logic signed [DATA_WIDTH-1:0] res_score,
  output logic                         res_err,
  output logic                         busy
);

  if (NUM_CLASSES < 2 || NUM_CLASSES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("mnist_infer_seq: illegal parameter combination");
  end

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_START, S_WAIT, S_SCAN, S_RESP} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  state_t                       state_q, state_d;
  logic [3:0]                   idx_q, idx_d;
  logic signed [DATA_WIDTH-1:0] best_score_q, best_score_d;
  logic [3:0]                   best_idx_q, best_idx_d;
  logic [3:0]                   res_digit_q, res_digit_d;
  logic signed [DATA_WIDTH-1:0] res_score_q, res_score_d;
  logic                         req_ready_q, req_ready_d;
  logic                         busy_q, busy_d;
  logic                         eng_reset_q, eng_reset_d;
  logic                         eng_start_q, eng_start_d;
  logic                         res_valid_q, res_valid_d;
  logic                         take;

`ifdef SEQ_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        res_err_q, res_err_d;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = '0;
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    res_digit_d  = res_digit_q;
    res_score_d  = res_score_q;
`ifdef SEQ_TIMEOUT_EN
    res_err_d    = res_err_q;
    wd_cnt_d     = '0;
`endif
    // k=0 loads unconditionally; strict compare afterwards keeps the lowest index on ties
    take = (idx_q == 4'd0) || (eng_out > best_score_q);

    case (state_q)
      S_IDLE:  if (req_valid && req_ready_q) state_d = S_CLR;
      S_CLR:   state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_done) state_d = S_SCAN;
`ifdef SEQ_TIMEOUT_EN
        else if (wd_cnt_q == WD_LAST) begin
          state_d     = S_RESP;
          res_digit_d = '0;
          res_score_d = '0;
          res_err_d   = 1'b1;
        end else wd_cnt_d = wd_cnt_q + 16'd1;
`endif
      end
      S_SCAN: begin
        if (take) begin
          best_score_d = eng_out;
          best_idx_d   = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d     = S_RESP;
          res_digit_d = take ? idx_q : best_idx_q;
          res_score_d = take ? eng_out : best_score_q;
`ifdef SEQ_TIMEOUT_EN
          res_err_d   = 1'b0;
`endif
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_RESP: begin
        if (res_valid_q && res_ready) begin
          state_d = S_IDLE;
`ifdef SEQ_TIMEOUT_EN
          res_err_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    eng_reset_d = (state_d == S_CLR);
    eng_start_d = (state_d == S_START);
    res_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      res_digit_q  <= '0;
      res_score_q  <= '0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      eng_reset_q  <= 1'b0;
      eng_start_q  <= 1'b0;
      res_valid_q  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_cnt_q     <= '0;
      res_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
      res_digit_q  <= res_digit_d;
      res_score_q  <= res_score_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      eng_reset_q  <= eng_reset_d;
      eng_start_q  <= eng_start_d;
      res_valid_q  <= res_valid_d;
`ifdef SEQ_TIMEOUT_EN
      wd_cnt_q     <= wd_cnt_d;
      res_err_q    <= res_err_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign eng_reset   = eng_reset_q;
  assign eng_start   = eng_start_q;
  assign eng_out_idx = idx_q;
  assign res_valid   = res_valid_q;
  assign res_digit   = res_digit_q;
  assign res_score   = res_score_q;
`ifdef SEQ_TIMEOUT_EN
  assign res_err     = res_err_q;
`else
  assign res_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mnist_infer_seq.sv
// Randomized bench for mnist_infer_seq with a behavioural engine and an argmax reference model.
module tb_mnist_infer_seq;
  localparam int NUM = 10;

  logic              clk, rst, req_valid, req_ready, eng_reset, eng_start, eng_done;
  logic [3:0]        eng_out_idx;
  logic signed [8:0] eng_out;
  logic              res_valid, res_ready, res_err, busy;
  logic [3:0]        res_digit;
  logic signed [8:0] res_score;

  logic signed [8:0] scores [16];
  int                lat_cfg;
  int                n_checks, n_pass;

  mnist_infer_seq #(.DATA_WIDTH(9), .NUM_CLASSES(NUM), .TIMEOUT_CYCLES(65535)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .eng_reset(eng_reset), .eng_start(eng_start), .eng_done(eng_done),
    .eng_out_idx(eng_out_idx), .eng_out(eng_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_digit(res_digit), .res_score(res_score),
    .res_err(res_err), .busy(busy)
  );

  assign eng_out = scores[eng_out_idx];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Engine: done rises lat_cfg cycles after start and stays high (stale) until the cycle after the next start
  initial begin
    int  cd;
    logic after_start;
    eng_done = 1'b0; cd = 0; after_start = 1'b0;
    forever begin
      @(negedge clk);
      if (after_start) eng_done = 1'b0;
      after_start = eng_start;
      if (eng_start) cd = lat_cfg;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) eng_done = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic void ref_argmax(output int dig, output int sc);
    dig = 0;
    sc  = int'(scores[0]);
    for (int i = 1; i < NUM; i++)
      if (int'(scores[i]) > sc) begin
        sc  = int'(scores[i]);
        dig = i;
      end
  endfunction

  task automatic rand_scores();
    for (int i = 0; i < 16; i++) scores[i] = (i < NUM) ? 9'($urandom_range(0, 511)) : 9'sd0;
  endtask

  task automatic run_txn(input int lat, input int bp, input bit keep_req);
    int n, exp_dig, exp_sc, idx_bad, pulse_bad, hold_bad, waitn, exp_k;
    logic [3:0] held_d;
    logic signed [8:0] held_s;
    ref_argmax(exp_dig, exp_sc);
    lat_cfg   = lat;
    res_ready = (bp == 0);
    waitn = 0;
    while (!req_ready && waitn < 100) begin
      @(negedge clk);
      waitn++;
    end
    check("req_ready_wait", int'(req_ready), 1);
    req_valid = 1'b1;
    @(negedge clk);
    if (!keep_req) req_valid = 1'b0;
    check("eng_reset_T1", int'(eng_reset), 1);
    check("busy_T1", int'(busy), 1);
    @(negedge clk);
    check("eng_reset_T2", int'(eng_reset), 0);
    check("eng_start_T2", int'(eng_start), 1);
    n = 0; idx_bad = 0; pulse_bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (eng_start || eng_reset) pulse_bad++;
      if (!res_valid) begin
        exp_k = (n > lat) ? n - lat - 1 : 0;
        if (int'(eng_out_idx) != exp_k) idx_bad++;
      end
    end while (!res_valid && n < lat + 40);
    check("latency", n, lat + NUM + 1);
    check("pulse_width", pulse_bad, 0);
    check("idx_seq", idx_bad, 0);
    check("idx_resp", int'(eng_out_idx), 0);
    check("digit", int'(res_digit), exp_dig);
    check("score", int'(res_score), exp_sc);
    check("res_err", int'(res_err), 0);
    if (bp > 0) begin
      held_d = res_digit; held_s = res_score; hold_bad = 0;
      for (int i = 0; i < bp; i++) begin
        if (i == bp / 2) req_valid = 1'b1;
        @(negedge clk);
        if (i == bp / 2) begin
          check("req_ready_resp", int'(req_ready), 0);
          req_valid = keep_req;
        end
        if (!res_valid || res_digit != held_d || res_score != held_s) hold_bad++;
      end
      check("bp_hold", hold_bad, 0);
      res_ready = 1'b1;
    end
    @(negedge clk);
    check("res_valid_drop", int'(res_valid), 0);
    check("req_ready_back", int'(req_ready), 1);
    check("busy_idle", int'(busy), 0);
    $display("txn lat=%0d bp=%0d digit=%0d score=%0d exp=%0d/%0d", lat, bp, res_digit, res_score, exp_dig, exp_sc);
  endtask

  initial begin
    int nom [NUM];
    int waitn;
    n_checks = 0; n_pass = 0;
    rst = 1'b0; req_valid = 1'b0; res_ready = 1'b1; lat_cfg = 5;
    for (int i = 0; i < 16; i++) scores[i] = 9'sd0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_eng_reset", int'(eng_reset), 0);
    check("rst_eng_start", int'(eng_start), 0);
    check("rst_idx", int'(eng_out_idx), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_digit", int'(res_digit), 0);
    check("rst_score", int'(res_score), 0);
    check("rst_err", int'(res_err), 0);
    rst = 1'b1;
    @(negedge clk);

    nom = '{-5, 3, 120, 7, -100, 0, 50, 119, 2, 1};
    for (int i = 0; i < NUM; i++) scores[i] = 9'(nom[i]);
    run_txn(100, 0, 1'b0);

    for (int i = 0; i < NUM; i++) scores[i] = -9'sd256;
    run_txn(7, 20, 1'b0);

    for (int i = 0; i < NUM; i++) scores[i] = 9'($urandom_range(0, 510) - 256);
    scores[4] = 9'sd255;
    scores[9] = 9'sd255;
    run_txn(12, 0, 1'b0);

    rand_scores();
    run_txn($urandom_range(2, 30), 0, 1'b1);
    rand_scores();
    run_txn($urandom_range(2, 30), 0, 1'b0);

    rand_scores();
    lat_cfg = 6;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    waitn = 0;
    while (eng_out_idx != 4'd5 && waitn < 100) begin
      @(negedge clk);
      waitn++;
    end
    check("scan_k5", int'(eng_out_idx), 5);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_req_ready", int'(req_ready), 1);
    check("mid_rst_res_valid", int'(res_valid), 0);
    check("mid_rst_idx", int'(eng_out_idx), 0);
    check("mid_rst_busy", int'(busy), 0);
    rst = 1'b1;
    @(negedge clk);
    $display("txn mid-scan reset applied");
    run_txn(9, 0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      rand_scores();
      run_txn($urandom_range(2, 40), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
